// File: rtl/axi4_lite_master.sv
// Simple-bus to AXI4-lite master bridge: one AXI transaction per wen/ren request.
// Optional response timeout with a DRAIN state is compiled in by AXI4_LITE_MASTER_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for sys_wen_i / sys_ren_i
// WREQ  | awvalid/wvalid outstanding, each drops on its own handshake
// WRSP  | both write handshakes done, waiting for bvalid
// RREQ  | arvalid outstanding
// RRSP  | waiting for rvalid
// DRAIN | timed out, already acked with error; finishing open handshakes silently
module axi4_lite_master #(
  parameter int         AXI_DW   = 32,
  parameter int         AXI_AW   = 32,
  parameter int         AXI_SW   = AXI_DW >> 3,
  parameter logic [2:0] AXI_PROT = 3'b000,
  parameter int         TO_CYC   = 32
) (
  input  logic              axi_clk_i,
  input  logic              axi_rstn_i,
  input  logic [AXI_AW-1:0] sys_addr_i,
  input  logic [AXI_DW-1:0] sys_wdata_i,
  input  logic [AXI_SW-1:0] sys_sel_i,
  input  logic              sys_wen_i,
  input  logic              sys_ren_i,
  output logic [AXI_DW-1:0] sys_rdata_o,
  output logic              sys_err_o,
  output logic              sys_ack_o,
  output logic [AXI_AW-1:0] axi_awaddr_o,
  output logic [2:0]        axi_awprot_o,
  output logic              axi_awvalid_o,
  input  logic              axi_awready_i,
  output logic [AXI_DW-1:0] axi_wdata_o,
  output logic [AXI_SW-1:0] axi_wstrb_o,
  output logic              axi_wvalid_o,
  input  logic              axi_wready_i,
  input  logic [1:0]        axi_bresp_i,
  input  logic              axi_bvalid_i,
  output logic              axi_bready_o,
  output logic [AXI_AW-1:0] axi_araddr_o,
  output logic [2:0]        axi_arprot_o,
  output logic              axi_arvalid_o,
  input  logic              axi_arready_i,
  input  logic [AXI_DW-1:0] axi_rdata_i,
  input  logic [1:0]        axi_rresp_i,
  input  logic              axi_rvalid_i,
  output logic              axi_rready_o
);

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, WREQ, WRSP, RREQ, RRSP, DRAIN} state_t;
  localparam logic [7:0] TO_CNT = 8'(TO_CYC);
  logic [7:0] to_cnt_q, to_cnt_d;
  logic       need_b_q, need_b_d, need_r_q, need_r_d;
`else
  typedef enum logic [2:0] {IDLE, WREQ, WRSP, RREQ, RRSP} state_t;
  localparam int unused_to_cyc = TO_CYC;
`endif

  state_t state_q, state_d;

  logic [AXI_AW-1:0] awaddr_d, araddr_d;
  logic [AXI_DW-1:0] wdata_d, rdata_d;
  logic [AXI_SW-1:0] wstrb_d;
  logic awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic ack_d, err_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic busy_pend_q, busy_pend_d;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, busy_req;
  logic unused_resp;

  assign axi_awprot_o = AXI_PROT;
  assign axi_arprot_o = AXI_PROT;
  assign unused_resp  = axi_bresp_i[0] ^ axi_rresp_i[0];

  assign aw_hs = axi_awvalid_o & axi_awready_i;
  assign w_hs  = axi_wvalid_o  & axi_wready_i;
  assign b_hs  = axi_bvalid_i  & axi_bready_o;
  assign ar_hs = axi_arvalid_o & axi_arready_i;
  assign r_hs  = axi_rvalid_i  & axi_rready_o;

  assign busy_req = (state_q == IDLE) ? (sys_wen_i & sys_ren_i) : (sys_wen_i | sys_ren_i);

  always_comb begin
    state_d     = state_q;
    awaddr_d    = axi_awaddr_o;
    wdata_d     = axi_wdata_o;
    wstrb_d     = axi_wstrb_o;
    araddr_d    = axi_araddr_o;
    rdata_d     = sys_rdata_o;
    awvalid_d   = axi_awvalid_o;
    wvalid_d    = axi_wvalid_o;
    arvalid_d   = axi_arvalid_o;
    bready_d    = 1'b0;
    rready_d    = 1'b0;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    busy_pend_d = busy_pend_q;
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    need_b_d    = need_b_q;
    need_r_d    = need_r_q;
`endif

    case (state_q)
      IDLE: begin
        if (sys_wen_i) begin
          awaddr_d  = sys_addr_i;
          wdata_d   = sys_wdata_i;
          wstrb_d   = sys_sel_i;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          bready_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WREQ;
        end else if (sys_ren_i) begin
          araddr_d  = sys_addr_i;
          arvalid_d = 1'b1;
          state_d   = RREQ;
        end
      end
      WREQ: begin
        bready_d = 1'b1;
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) state_d = WRSP;
      end
      WRSP: begin
        bready_d = 1'b1;
        if (b_hs) begin
          bready_d = 1'b0;
          ack_d    = 1'b1;
          err_d    = axi_bresp_i[1];
          state_d  = IDLE;
        end
      end
      RREQ: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RRSP;
        end
      end
      RRSP: begin
        rready_d = 1'b1;
        if (r_hs) begin
          rready_d = 1'b0;
          rdata_d  = axi_rdata_i;
          ack_d    = 1'b1;
          err_d    = axi_rresp_i[1];
          state_d  = IDLE;
        end
      end
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
      DRAIN: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if (ar_hs) arvalid_d = 1'b0;
        need_b_d = need_b_q & ~b_hs;
        need_r_d = need_r_q & ~r_hs;
        bready_d = need_b_d;
        rready_d = need_r_d;
        if (!need_b_d && !need_r_d && !awvalid_d && !wvalid_d && !arvalid_d) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    if (state_q == IDLE)       to_cnt_d = '0;
    else if (state_q == DRAIN) to_cnt_d = to_cnt_q;
    else                       to_cnt_d = to_cnt_q + 8'd1;
    // A completion landing in the timeout cycle wins; the timeout is then moot.
    if (state_q != IDLE && state_q != DRAIN && !ack_d && to_cnt_q == TO_CNT) begin
      ack_d    = 1'b1;
      err_d    = 1'b1;
      state_d  = DRAIN;
      need_b_d = (state_q == WREQ) || (state_q == WRSP);
      need_r_d = (state_q == RREQ) || (state_q == RRSP);
    end
`endif

    // Busy errors yield to a completion ack and are held one deep.
    if (ack_d) begin
      if (busy_req) busy_pend_d = 1'b1;
    end else if (busy_pend_q) begin
      ack_d       = 1'b1;
      err_d       = 1'b1;
      busy_pend_d = 1'b0;
    end else if (busy_req) begin
      ack_d = 1'b1;
      err_d = 1'b1;
    end
  end

  always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
    if (!axi_rstn_i) begin
      state_q       <= IDLE;
      axi_awaddr_o  <= '0;
      axi_wdata_o   <= '0;
      axi_wstrb_o   <= '0;
      axi_araddr_o  <= '0;
      sys_rdata_o   <= '0;
      axi_awvalid_o <= 1'b0;
      axi_wvalid_o  <= 1'b0;
      axi_arvalid_o <= 1'b0;
      axi_bready_o  <= 1'b0;
      axi_rready_o  <= 1'b0;
      sys_ack_o     <= 1'b0;
      sys_err_o     <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      busy_pend_q   <= 1'b0;
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
      to_cnt_q      <= '0;
      need_b_q      <= 1'b0;
      need_r_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      axi_awaddr_o  <= awaddr_d;
      axi_wdata_o   <= wdata_d;
      axi_wstrb_o   <= wstrb_d;
      axi_araddr_o  <= araddr_d;
      sys_rdata_o   <= rdata_d;
      axi_awvalid_o <= awvalid_d;
      axi_wvalid_o  <= wvalid_d;
      axi_arvalid_o <= arvalid_d;
      axi_bready_o  <= bready_d;
      axi_rready_o  <= rready_d;
      sys_ack_o     <= ack_d;
      sys_err_o     <= err_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      busy_pend_q   <= busy_pend_d;
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
      need_b_q      <= need_b_d;
      need_r_q      <= need_r_d;
`endif
    end
  end

endmodule
